// File: rtl/plain_poly_evaluate.sv
// plain_poly_evaluate
//   Evaluates one polynomial with GF256 coefficients at T points of GF(2^32)
//   using Horner's rule. Coefficients are fetched once each, highest index
//   first, from a synchronous byte memory. Every point's accumulator is
//   updated per coefficient through a shared external GF32 multiplier.
//
// Ports
//   i_clk, i_rst        clock, asynchronous active-high reset
//   i_start             start pulse, only honoured in IDLE
//   i_r                 T packed points, slot j = [32j+31:32j]
//   o_coef_addr/o_coef_rd/i_coef   coefficient memory (1-cycle read latency)
//   o_start_mul32/o_x_mul32/o_y_mul32/i_o_mul32/i_done_mul32  multiplier
//   o_eval_out          T packed results (live accumulators)
//   o_done              one-cycle completion pulse
//   o_busy              high whenever not IDLE
module plain_poly_evaluate #(
  parameter string PARAMETER_SET = "L1",
  parameter int    M      = (PARAMETER_SET == "L5") ? 480 :
                            (PARAMETER_SET == "L3") ? 352 : 230,
  parameter int    T      = (PARAMETER_SET == "L5") ? 4 : 3,
  parameter int    N_COEF = (PARAMETER_SET == "L5") ? 278 :
                            (PARAMETER_SET == "L3") ? 193 : 126
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [32*T-1:0]       i_r,
  output logic [$clog2(M)-1:0]  o_coef_addr,
  output logic                  o_coef_rd,
  input  logic [7:0]            i_coef,
  output logic                  o_start_mul32,
  output logic [31:0]           o_x_mul32,
  output logic [31:0]           o_y_mul32,
  input  logic [31:0]           i_o_mul32,
  input  logic                  i_done_mul32,
  output logic [32*T-1:0]       o_eval_out,
  output logic                  o_done,
  output logic                  o_busy
);

  localparam int AW = $clog2(M);
  localparam int JW = (T > 1) ? $clog2(T) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_RD, S_LOAD_CAP, S_RD, S_CAP, S_MSTART, S_MWAIT, S_DONE
  } state_t;

  state_t                r_state, w_nxt;
  logic [AW-1:0]         r_i;
  logic [JW-1:0]         r_j;
  logic [7:0]            r_coef;
  logic [T-1:0][31:0]    r_pts;
  logic [T-1:0][31:0]    r_acc;

  logic                  w_last_pt;
  logic                  w_last_coef;
  logic                  w_mul_ret;

  assign w_last_pt   = (r_j == JW'(T - 1));
  assign w_last_coef = (r_i == '0);
  // A product is only taken while one is outstanding; stray pulses elsewhere drop.
  assign w_mul_ret   = (r_state == S_MWAIT) && i_done_mul32;

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_nxt;
  end

  // Next-state logic
  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      S_IDLE:     if (i_start) w_nxt = S_LOAD_RD;
      S_LOAD_RD:  w_nxt = S_LOAD_CAP;
      S_LOAD_CAP: w_nxt = w_last_coef ? S_DONE : S_RD;
      S_RD:       w_nxt = S_CAP;
      S_CAP:      w_nxt = S_MSTART;
      S_MSTART:   w_nxt = S_MWAIT;
      S_MWAIT:
        if (i_done_mul32) begin
          if (!w_last_pt)       w_nxt = S_MSTART;
          else if (w_last_coef) w_nxt = S_DONE;
          else                  w_nxt = S_RD;
        end
      S_DONE:     w_nxt = S_IDLE;
      default:    w_nxt = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    o_coef_rd     = (r_state == S_LOAD_RD) || (r_state == S_RD);
    o_coef_addr   = o_coef_rd ? r_i : '0;
    o_start_mul32 = (r_state == S_MSTART);
    o_done        = (r_state == S_DONE);
    o_busy        = (r_state != S_IDLE);
    o_x_mul32     = '0;
    o_y_mul32     = '0;
    // Operands come straight from registers that do not move until the
    // product returns, so they stay stable for the whole multiply.
    if ((r_state == S_MSTART) || (r_state == S_MWAIT)) begin
      o_x_mul32 = r_acc[r_j];
      o_y_mul32 = r_pts[r_j];
    end
  end

  assign o_eval_out = r_acc;

  // Datapath
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_i    <= '0;
      r_j    <= '0;
      r_coef <= '0;
      r_pts  <= '0;
      r_acc  <= '0;
    end else begin
      unique case (r_state)
        S_IDLE:
          if (i_start) begin
            r_pts <= i_r;
            r_i   <= AW'(N_COEF - 1);
            r_j   <= '0;
          end
        S_LOAD_CAP: begin
          // Highest coefficient seeds every accumulator.
          r_acc <= {T{24'b0, i_coef}};
          if (!w_last_coef) r_i <= r_i - 1'b1;
        end
        S_CAP: begin
          r_coef <= i_coef;
          r_j    <= '0;
        end
        S_MWAIT:
          if (w_mul_ret) begin
            r_acc[r_j] <= i_o_mul32 ^ {24'b0, r_coef};
            if (!w_last_pt)        r_j <= r_j + 1'b1;
            else if (!w_last_coef) r_i <= r_i - 1'b1;
          end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/plain_poly_evaluate.md
Name: plain_poly_evaluate

Overview:
- Evaluates one plain polynomial with GF256 coefficients at T points r_j in GF(2^32), using Horner's rule.
- Sits directly upstream of the plain-broadcast stage and serves its evaluate request. The broadcast stage supplies the start pulse, the evaluation points and the Q/S coefficient stream, and consumes the T packed results plus done.
- Coefficients are read once each from a synchronous byte memory. All T points are updated per coefficient through a shared external GF32 multiplier with a start/done handshake.

Parameters:
- PARAMETER_SET, "L1", selects the M/T defaults.
- M, 230 (L1) / 352 (L3) / 480 (L5): sizes the coefficient address width `CLOG2(M)`.
- T, 3 (4 for L5): number of evaluation points.
- N_COEF, 126 (L1) / 193 (L3) / 278 (L5): number of coefficients c_0..c_{N_COEF-1}. Must be ≥ 1 and ≤ M.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous active-high reset
- i_start  in  1  start pulse; sampled only in IDLE
- i_r  in  32*T  points; slot j = bits [32j+31:32j]
- o_coef_addr  out  `CLOG2(M)`  coefficient byte address
- o_coef_rd  out  1  read strobe; data valid on i_coef the next cycle
- i_coef  in  8  coefficient byte
- o_start_mul32  out  1  one-cycle multiply request
- o_x_mul32  out  32  multiplicand (accumulator)
- o_y_mul32  out  32  multiplier (point)
- i_o_mul32  in  32  product; valid when i_done_mul32 = 1
- i_done_mul32  in  1  one-cycle product-valid pulse
- o_eval_out  out  32*T  results; slot j = P(r_j)
- o_done  out  1  one-cycle completion pulse
- o_busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async, any state): state IDLE; all outputs 0; accumulators, latched points and counters 0. Reset mid-operation aborts with no done pulse.
- Embedding: a byte c lifts to {24'b0, c}. GF(2^32) addition is XOR, done internally. Multiplication is external only.
- On IDLE with i_start: latch i_r into r_reg (later i_r changes are ignored); coefficient index i <= N_COEF-1; point index j <= 0.
- States and transitions:
  - IDLE: wait for i_start.
  - LOAD_RD: o_coef_rd=1, o_coef_addr=i (N_COEF-1).
  - LOAD_CAP: acc_j <= lift(i_coef) for every j. If i==0 -> DONE, else i<=i-1 -> RD.
  - RD: o_coef_rd=1, o_coef_addr=i.
  - CAP: coef_reg <= i_coef; j<=0 -> MSTART.
  - MSTART: o_start_mul32=1 for exactly this cycle; o_x_mul32=acc_j, o_y_mul32=r_reg_j -> MWAIT.
  - MWAIT: operands held stable. On i_done_mul32: acc_j <= i_o_mul32 ^ lift(coef_reg). Then:
    - if j<T-1: j<=j+1 -> MSTART;
    - else if i==0 -> DONE;
    - else i<=i-1 -> RD.
  - DONE: o_done=1 for one cycle -> IDLE.
- o_coef_rd is asserted only in LOAD_RD and RD, exactly once per coefficient, in descending address order.
- o_start_mul32 is never asserted while a product is outstanding.
- i_done_mul32 outside MWAIT is ignored.
- o_eval_out = acc registers continuously. The value is final when o_done is high and holds until the next accepted start.
- o_busy covers every state except IDLE, including DONE. i_start while busy is ignored.
- Latency: with i_start sampled in cycle 0 and the multiplier returning done exactly D≥1 cycles after its start cycle, o_done is high in cycle 3 + (N_COEF-1)·(2 + T·(D+1)). N_COEF=1 gives cycle 3, with no multiplications.

Test Plan:
- N_COEF=1, i_coef[0]=0x5A, T=3, any r -> every slot 0x0000005A; o_done in cycle 3; zero o_start_mul32 pulses.
- N_COEF=4, coefs 0x01,0x02,0x03,0x04, r_j=1 for all j, model multiplier with D=2 -> every slot 0x00000004 (XOR of all coefs); o_done in cycle 3+3·(2+3·3)=36; exactly 9 multiplies; read addresses 3,2,1,0.
- Same coefs, r_j=0 -> slots = 0x00000001 (c_0). Also verify each multiply's operands equal (acc_j, 0).
- N_COEF=126, random coefs and r, multiplier with random D in 1..6 -> results match a software Horner GF(2^32) model; o_x/o_y stable throughout each MWAIT; stray i_done_mul32 injected in RD is ignored.
- i_start pulsed during MWAIT, and i_r changed after start -> no restart; results use the points latched at start.
- Assert i_rst during the 5th MWAIT -> all outputs 0 immediately, no o_done. A fresh start then completes correctly.
